jellyvl_cdc_event_arbiter: RTL and testbench
============================================

JELLYVL_CDC_EVENT_ARBITER -- requirements
Module: jellyvl_cdc_event_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters, range 1..16.
REQ-002 SHALL have parameter DATA_BITS, default 8: payload width per requester.
REQ-003 SHALL have parameter TIMEOUT, default 1024: cycles allowed in WAIT before an error is raised.
REQ-004 SHALL derive localparam ID_BITS = max(1, clog2(N)).
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1: single clock; all logic is on posedge clk.
REQ-007 SHALL have port s_req, input, N: level request per requester, held until the matching s_ack.
REQ-008 SHALL have port s_data, input, N*DATA_BITS: payload, slice i belongs to requester i.
REQ-009 SHALL have port s_ack, output, N: one-cycle completion pulse per requester.
REQ-010 SHALL have port m_toggle, output, 1: request toggle, to be sent through the single-bit CDC synchronizer.
REQ-011 SHALL have port m_id, output, ID_BITS: granted requester index, stable while a transfer is in flight.
REQ-012 SHALL have port m_data, output, DATA_BITS: latched payload, stable while a transfer is in flight.
REQ-013 SHALL have port m_ack_toggle, input, 1: far-side acknowledge toggle, already synchronized into clk.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-015 SHALL have port err, output, 1: sticky timeout flag; tied to 0 when the feature is compiled out.
REQ-016 SHALL have port err_clear, input, 1: clears err.

Function
REQ-017 SHALL implement states IDLE, SEND, WAIT and RECOVER.
REQ-018 SHALL, in IDLE with any s_req set, grant round-robin starting at index last_grant+1 (mod N), latch m_id and m_data, and go to SEND.
REQ-019 SHALL, in SEND, invert m_toggle and go to WAIT, so m_data/m_id are stable one cycle before the toggle edge.
REQ-020 SHALL, in WAIT when m_ack_toggle == m_toggle, pulse s_ack[m_id] for one cycle, set last_grant = m_id, and return to IDLE.
REQ-021 SHALL keep the minimum grant-to-next-grant time at 3 cycles plus the round-trip synchronizer latency.
REQ-022 SHALL never change m_data, m_id or m_toggle in WAIT or RECOVER.
REQ-023 SHALL complete a transfer and still pulse s_ack if the requester deasserts s_req after the grant.
REQ-024 SHALL ignore requests that arrive while busy until the machine returns to IDLE; they are not lost while s_req is held.
REQ-025 SHALL ignore m_ack_toggle transitions in IDLE and SEND.
REQ-026 SHALL give err_clear priority over a simultaneous err set.

Reset
REQ-027 SHALL, on reset: state=IDLE, m_toggle=0, m_id=0, m_data=0, s_ack=0, busy=0, err=0, last_grant=N-1 (first grant goes to index 0).
REQ-028 SHALL require the far side to be reset together with this block; a reset mid-transfer abandons the transfer without an s_ack pulse.

Configuration
REQ-029 SHALL, with JELLYVL_CDC_EVENT_ARBITER_TIMEOUT_EN defined, count cycles in WAIT; on reaching TIMEOUT it sets err and goes to RECOVER with no s_ack.
REQ-030 SHALL, in RECOVER, wait for m_ack_toggle == m_toggle, then return to IDLE without pulsing s_ack.
REQ-031 SHALL, without the macro, omit the counter and RECOVER, hold err at 0, and let WAIT wait indefinitely.

Structure
REQ-032 SHALL place the state enum typedef in package jellyvl_cdc_event_arbiter_pkg.
REQ-033 SHALL implement the grant selection in sub-module jellyvl_rr_arbiter: combinational, inputs are the N-bit request vector and last_grant; outputs are the grant index and a valid bit.

Verification
REQ-034 SHALL cover: N=4, s_req=0001, ack looped back with a 3-cycle delay -> m_toggle 0->1 two cycles after the request; s_ack[0] pulses once; m_data equals slice 0.
REQ-035 SHALL cover: s_req=1111 held -> grant order 0,1,2,3,0; every s_ack is one cycle wide.
REQ-036 SHALL cover: s_req[2] dropped during WAIT -> transfer completes and s_ack[2] still pulses.
REQ-037 SHALL cover: macro defined, TIMEOUT=16, ack never returned -> err=1 after 16 WAIT cycles; the state stays RECOVER until the ack is forced, then goes to IDLE with no s_ack pulse.
REQ-038 SHALL cover: reset asserted mid-WAIT -> all outputs at their reset values asynchronously; the first grant after release goes to index 0.
REQ-039 SHALL cover: err_clear and timeout in the same cycle -> err reads 0 in the next cycle.

Source files
------------

// File: rtl/jellyvl_cdc_event_arbiter_pkg.sv
// jellyvl_cdc_event_arbiter_pkg
//   Shared types and helpers for the CDC event arbiter.
//   - state_t     : arbiter FSM states (IDLE, SEND, WAIT, RECOVER)
//   - clog2_min1  : ceil(log2(value)), never less than 1 bit
package jellyvl_cdc_event_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/jellyvl_cdc_event_arbiter_if.sv
// jellyvl_cdc_event_arbiter_if
//   Bundle between the requesters / far-side toggle link and the arbiter.
//   Parameters: N requesters, DATA_BITS payload per requester.
//   Signals:
//     s_req[N], s_data[N*DATA_BITS]  requester levels and payloads
//     s_ack[N]                       one-cycle completion pulses
//     m_toggle, m_id, m_data         outgoing toggle event and its payload
//     m_ack_toggle                   far-side acknowledge toggle (already in clk)
//     busy, err, err_clear           status and sticky-error clear
//   Modports: slave  = arbiter side, master = requesters / far side.
interface jellyvl_cdc_event_arbiter_if
#(
  parameter int N         = 4,
  parameter int DATA_BITS = 8
);
  import jellyvl_cdc_event_arbiter_pkg::*;

  localparam int ID_BITS = clog2_min1(N);

  logic [N-1:0]           s_req;
  logic [N*DATA_BITS-1:0] s_data;
  logic [N-1:0]           s_ack;
  logic                   m_toggle;
  logic [ID_BITS-1:0]     m_id;
  logic [DATA_BITS-1:0]   m_data;
  logic                   m_ack_toggle;
  logic                   busy;
  logic                   err;
  logic                   err_clear;

  modport slave (
    input  s_req, s_data, m_ack_toggle, err_clear,
    output s_ack, m_toggle, m_id, m_data, busy, err
  );

  modport master (
    output s_req, s_data, m_ack_toggle, err_clear,
    input  s_ack, m_toggle, m_id, m_data, busy, err
  );

endinterface

// File: rtl/jellyvl_rr_arbiter.sv
// jellyvl_rr_arbiter
//   Combinational round-robin selector. Searches req starting at
//   last_grant+1 (mod N) and returns the first set index.
//   Ports: req[N], last_grant[ID_BITS] in; grant_id[ID_BITS], grant_valid out.
module jellyvl_rr_arbiter
#(
  parameter int N       = 4,
  parameter int ID_BITS = 2
)
(
  input  logic [N-1:0]       req,
  input  logic [ID_BITS-1:0] last_grant,
  output logic [ID_BITS-1:0] grant_id,
  output logic               grant_valid
);

  logic [ID_BITS-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester after
  // last_grant is the one left in grant_id.
  always_comb begin
    grant_id    = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = N; k >= 1; k--) begin
      idx = ID_BITS'((int'(last_grant) + k) % N);
      if (req[idx]) begin
        grant_id    = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jellyvl_cdc_event_arbiter.sv
// jellyvl_cdc_event_arbiter
//   Arbitrates N level requesters onto a single toggle-based CDC event link.
//   A granted payload is latched one cycle before m_toggle flips, and the
//   transfer completes when the synchronized m_ack_toggle matches m_toggle.
//   Ports:
//     reset  asynchronous active-high reset
//     clk    single clock
//     bus    jellyvl_cdc_event_arbiter_if.slave (requests, toggle link, status)
//   Optional feature: define JELLYVL_CDC_EVENT_ARBITER_TIMEOUT_EN to add a
//   WAIT timeout (TIMEOUT cycles) that sets sticky err and enters RECOVER.
module jellyvl_cdc_event_arbiter
  import jellyvl_cdc_event_arbiter_pkg::*;
#(
  parameter int N         = 4,
  parameter int DATA_BITS = 8,
  parameter int TIMEOUT   = 1024
)
(
  input  logic                          reset,
  input  logic                          clk,
  jellyvl_cdc_event_arbiter_if.slave    bus
);

  localparam int ID_BITS = clog2_min1(N);

  state_t               state_reg;
  logic                 m_toggle_reg;
  logic [ID_BITS-1:0]   m_id_reg;
  logic [DATA_BITS-1:0] m_data_reg;
  logic [N-1:0]         s_ack_reg;
  logic [ID_BITS-1:0]   last_grant_reg;

  logic [N-1:0]         req_masked;
  logic [ID_BITS-1:0]   grant_id;
  logic                 grant_valid;
  logic [DATA_BITS-1:0] grant_data;
  logic                 ack_match;
  logic                 timeout_hit;

  // The requester just acked still holds s_req during its s_ack cycle;
  // masking it stops a spurious second grant of the same event.
  assign req_masked = bus.s_req & ~s_ack_reg;
  assign ack_match  = (bus.m_ack_toggle == m_toggle_reg);
  assign grant_data = bus.s_data[grant_id*DATA_BITS +: DATA_BITS];

  jellyvl_rr_arbiter #(
    .N       (N),
    .ID_BITS (ID_BITS)
  ) u_rr_arbiter (
    .req         (req_masked),
    .last_grant  (last_grant_reg),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

`ifdef JELLYVL_CDC_EVENT_ARBITER_TIMEOUT_EN
  localparam int TIMER_BITS = clog2_min1(TIMEOUT);

  logic [TIMER_BITS-1:0] timer_reg;
  logic                  err_reg;

  assign timeout_hit = (state_reg == ST_WAIT) && !ack_match &&
                       (timer_reg == TIMER_BITS'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      timer_reg <= (state_reg == ST_WAIT) ? timer_reg + TIMER_BITS'(1) : '0;
      // A clear in the same cycle as a new timeout wins.
      if (bus.err_clear) begin
        err_reg <= 1'b0;
      end else if (timeout_hit) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign bus.err = err_reg;
`else
  logic unused_ok;
  assign unused_ok   = bus.err_clear | (TIMEOUT == 0);
  assign timeout_hit = 1'b0;
  assign bus.err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      m_toggle_reg   <= 1'b0;
      m_id_reg       <= '0;
      m_data_reg     <= '0;
      s_ack_reg      <= '0;
      last_grant_reg <= ID_BITS'(N - 1);
    end else begin
      s_ack_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_valid) begin
            m_id_reg   <= grant_id;
            m_data_reg <= grant_data;
            state_reg  <= ST_SEND;
          end
        end
        ST_SEND: begin
          m_toggle_reg <= ~m_toggle_reg;
          state_reg    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ack_match) begin
            s_ack_reg[m_id_reg] <= 1'b1;
            last_grant_reg      <= m_id_reg;
            state_reg           <= ST_IDLE;
          end else if (timeout_hit) begin
            state_reg <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          // Let the late acknowledge drain so the toggle link is back in step.
          if (ack_match) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.s_ack    = s_ack_reg;
  assign bus.m_toggle = m_toggle_reg;
  assign bus.m_id     = m_id_reg;
  assign bus.m_data   = m_data_reg;
  assign bus.busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_jellyvl_cdc_event_arbiter.sv
// tb_jellyvl_cdc_event_arbiter
//   Self-checking bench for jellyvl_cdc_event_arbiter (N=4, DATA_BITS=8,
//   TIMEOUT=16). The far side is a 3-flop loopback of m_toggle that can be
//   frozen to withhold the acknowledge. Build with
//   JELLYVL_CDC_EVENT_ARBITER_TIMEOUT_EN to exercise the timeout path.
module tb_jellyvl_cdc_event_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic       clk;
  logic       reset;
  logic       loop_en;
  logic [2:0] ack_dly;
  int         errors;
  int         checks;
  int         model_last;

  jellyvl_cdc_event_arbiter_if #(.N(N), .DATA_BITS(DW)) bus();

  jellyvl_cdc_event_arbiter #(
    .N         (N),
    .DATA_BITS (DW),
    .TIMEOUT   (TO)
  ) dut (
    .reset (reset),
    .clk   (clk),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Far side: acknowledge toggle returns three cycles after m_toggle.
  always @(posedge clk or posedge reset) begin
    if (reset) ack_dly <= '0;
    else if (loop_en) ack_dly <= {ack_dly[1:0], bus.m_toggle};
  end
  assign bus.m_ack_toggle = ack_dly[2];

  // Reference: next grant is the first requester after the last granted one.
  function automatic int rr_model(input logic [N-1:0] req, input int last);
    int order[$];
    for (int k = 1; k <= N; k++) order.push_back((last + k) % N);
    foreach (order[j]) if (req[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.m_toggle !== 1'b0) begin errors++; $display("FAIL reset_m_toggle: got %b expected 0", bus.m_toggle); end
    checks++; if (bus.m_id !== 2'd0) begin errors++; $display("FAIL reset_m_id: got %0d expected 0", bus.m_id); end
    checks++; if (bus.m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h expected 00", bus.m_data); end
    checks++; if (bus.s_ack !== 4'b0000) begin errors++; $display("FAIL reset_s_ack: got %b expected 0000", bus.s_ack); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    reset = 1'b0;
    model_last = N - 1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_after_release: busy got %b expected 0", bus.busy); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    logic          tog0;
    int            acks;
    int            unstable;
    bus.s_data = 32'($urandom);
    d          = bus.s_data[DW-1:0];
    tog0       = bus.m_toggle;
    bus.s_req  = 4'b0001;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
    checks++; if (bus.m_toggle !== tog0) begin errors++; $display("FAIL single_toggle_early: got %b expected %b", bus.m_toggle, tog0); end
    checks++; if (bus.m_id !== 2'd0) begin errors++; $display("FAIL single_m_id: got %0d expected 0", bus.m_id); end
    checks++; if (bus.m_data !== d) begin errors++; $display("FAIL single_m_data: got %h expected %h", bus.m_data, d); end
    @(negedge clk);
    checks++; if (bus.m_toggle !== ~tog0) begin errors++; $display("FAIL single_toggle_edge: got %b expected %b", bus.m_toggle, ~tog0); end
    acks = 0; unstable = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.busy && (bus.m_data !== d || bus.m_id !== 2'd0)) unstable++;
      if (bus.s_ack !== 4'b0000) begin
        acks++;
        checks++; if (bus.s_ack !== 4'b0001) begin errors++; $display("FAIL single_ack_vec: got %b expected 0001", bus.s_ack); end
        bus.s_req = 4'b0000;
        model_last = 0;
      end
    end
    checks++; if (acks != 1) begin errors++; $display("FAIL single_ack_count: got %0d expected 1", acks); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL single_stable: got %0d changes expected 0", unstable); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy got %b expected 0", bus.busy); end
    $display("test_single: data=%h acks=%0d", d, acks);
  endtask

  task automatic test_round_robin();
    int       grants;
    int       inflight;
    int       exp;
    logic     prev_busy;
    logic [N-1:0] prev_ack;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_last = N - 1;
    bus.s_data = 32'($urandom);
    bus.s_req  = 4'b1111;
    grants = 0; inflight = 0; prev_busy = 1'b0; prev_ack = '0;
    for (int c = 0; c < 200 && grants < 5; c++) begin
      @(negedge clk);
      if (bus.s_ack !== 4'b0000) begin
        checks++; if (bus.s_ack !== (N'(1) << inflight) || prev_ack !== 4'b0000) begin errors++; $display("FAIL rr_ack: got %b prev %b expected %b once", bus.s_ack, prev_ack, N'(1) << inflight); end
        model_last = inflight;
      end
      if (bus.busy && !prev_busy) begin
        exp = rr_model(bus.s_req, model_last);
        checks++; if (int'(bus.m_id) != exp) begin errors++; $display("FAIL rr_grant%0d: got %0d expected %0d", grants, bus.m_id, exp); end
        $display("rr grant %0d -> id %0d", grants, bus.m_id);
        inflight = (exp < 0) ? 0 : exp;
        grants++;
      end
      prev_busy = bus.busy;
      prev_ack  = bus.s_ack;
    end
    checks++; if (grants != 5) begin errors++; $display("FAIL rr_grant_count: got %0d expected 5", grants); end
    bus.s_req = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.s_ack !== 4'b0000) model_last = inflight;
    end
  endtask

  task automatic test_drop();
    logic tog0;
    int   got;
    int   acks;
    bus.s_req = 4'b0100;
    tog0 = bus.m_toggle;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.m_toggle !== tog0) begin got = 1; break; end
    end
    checks++; if (got == 0) begin errors++; $display("FAIL drop_toggle: no toggle within 10 cycles expected one"); end
    bus.s_req = 4'b0000;
    acks = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.s_ack !== 4'b0000) begin
        acks++;
        checks++; if (bus.s_ack !== 4'b0100) begin errors++; $display("FAIL drop_ack_vec: got %b expected 0100", bus.s_ack); end
      end
    end
    checks++; if (acks != 1) begin errors++; $display("FAIL drop_ack_count: got %0d expected 1", acks); end
    model_last = 2;
    $display("test_drop: acks=%0d", acks);
  endtask

  task automatic test_random();
    int            transfers;
    int            inflight;
    int            exp;
    logic [DW-1:0] inflight_data;
    logic          prev_busy;
    logic [N-1:0]  acked;
    transfers = 0; inflight = 0; inflight_data = '0;
    prev_busy = bus.busy;
    for (int c = 0; c < 3000 && transfers < 30; c++) begin
      @(negedge clk);
      acked = '0;
      if (bus.busy && !prev_busy) begin
        exp = rr_model(bus.s_req, model_last);
        checks++; if (int'(bus.m_id) != exp) begin errors++; $display("FAIL rand_grant: got %0d expected %0d req %b", bus.m_id, exp, bus.s_req); end
        inflight = (exp < 0) ? 0 : exp;
        inflight_data = bus.s_data[inflight*DW +: DW];
        checks++; if (bus.m_data !== inflight_data) begin errors++; $display("FAIL rand_data: got %h expected %h", bus.m_data, inflight_data); end
        $display("rand grant id %0d data %h req %b", bus.m_id, bus.m_data, bus.s_req);
      end else if (bus.busy) begin
        checks++; if (int'(bus.m_id) != inflight || bus.m_data !== inflight_data) begin errors++; $display("FAIL rand_stable: got id %0d data %h expected id %0d data %h", bus.m_id, bus.m_data, inflight, inflight_data); end
      end
      if (bus.s_ack !== 4'b0000) begin
        checks++; if (bus.s_ack !== (N'(1) << inflight)) begin errors++; $display("FAIL rand_ack: got %b expected %b", bus.s_ack, N'(1) << inflight); end
        model_last = inflight;
        acked      = bus.s_ack;
        bus.s_req  = bus.s_req & ~bus.s_ack;
        transfers++;
      end
      for (int i = 0; i < N; i++) begin
        if (!bus.s_req[i] && !acked[i] && $urandom_range(0, 3) == 0) begin
          bus.s_data[i*DW +: DW] = DW'($urandom);
          bus.s_req[i] = 1'b1;
        end
      end
      prev_busy = bus.busy;
    end
    checks++; if (transfers < 30) begin errors++; $display("FAIL rand_progress: got %0d transfers expected 30", transfers); end
    bus.s_req = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.s_ack !== 4'b0000) model_last = inflight;
    end
  endtask

`ifdef JELLYVL_CDC_EVENT_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    logic tog0;
    int   got;
    int   early;
    int   stray;
    loop_en = 1'b0;
    bus.s_req = 4'b0010;
    tog0 = bus.m_toggle;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.m_toggle !== tog0) begin got = 1; break; end
    end
    checks++; if (got == 0) begin errors++; $display("FAIL to_toggle: no toggle within 10 cycles expected one"); end
    early = 0;
    repeat (TO - 1) begin
      @(negedge clk);
      if (bus.err !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL to_early_err: got %0d early cycles expected 0", early); end
    @(negedge clk);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL to_err_set: got %b expected 1", bus.err); end
    bus.s_req = 4'b0000;
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.s_ack !== 4'b0000) stray++;
    end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL to_recover_hold: busy got %b expected 1", bus.busy); end
    loop_en = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.s_ack !== 4'b0000) stray++;
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL to_recover_exit: busy got %b expected 0", bus.busy); end
    checks++; if (stray != 0) begin errors++; $display("FAIL to_no_ack: got %0d s_ack pulses expected 0", stray); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b expected 1", bus.err); end
    bus.err_clear = 1'b1;
    @(negedge clk);
    bus.err_clear = 1'b0;
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b expected 0", bus.err); end
    $display("test_timeout: stray=%0d", stray);
  endtask

  task automatic test_err_clear_collision();
    logic tog0;
    int   got;
    loop_en = 1'b0;
    bus.s_req = 4'b0001;
    tog0 = bus.m_toggle;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.m_toggle !== tog0) begin got = 1; break; end
    end
    checks++; if (got == 0) begin errors++; $display("FAIL clr_toggle: no toggle within 10 cycles expected one"); end
    repeat (TO - 1) @(negedge clk);
    bus.err_clear = 1'b1;
    @(negedge clk);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL clr_priority: err got %b expected 0", bus.err); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL clr_recover: busy got %b expected 1", bus.busy); end
    bus.err_clear = 1'b0;
    @(negedge clk);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL clr_stays: err got %b expected 0", bus.err); end
    bus.s_req = 4'b0000;
    loop_en = 1'b1;
    repeat (15) @(negedge clk);
    $display("test_err_clear_collision done");
  endtask
`else
  task automatic test_no_timeout();
    int errs_seen;
    int acks;
    loop_en = 1'b0;
    bus.s_req = 4'b0001;
    errs_seen = 0;
    repeat (3 * TO) begin
      @(negedge clk);
      if (bus.err !== 1'b0) errs_seen++;
    end
    checks++; if (errs_seen != 0) begin errors++; $display("FAIL nto_err: got %0d err cycles expected 0", errs_seen); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL nto_wait: busy got %b expected 1", bus.busy); end
    loop_en = 1'b1;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.s_ack !== 4'b0000) begin
        acks++;
        checks++; if (bus.s_ack !== 4'b0001) begin errors++; $display("FAIL nto_ack_vec: got %b expected 0001", bus.s_ack); end
        bus.s_req = 4'b0000;
      end
    end
    checks++; if (acks != 1) begin errors++; $display("FAIL nto_ack_count: got %0d expected 1", acks); end
    model_last = 0;
    $display("test_no_timeout: acks=%0d", acks);
  endtask
`endif

  task automatic test_reset_mid_wait();
    logic tog0;
    int   got;
    bus.s_req = 4'b0110;
    tog0 = bus.m_toggle;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.m_toggle !== tog0) begin got = 1; break; end
    end
    checks++; if (got == 0) begin errors++; $display("FAIL rst_toggle: no toggle within 10 cycles expected one"); end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.m_toggle !== 1'b0) begin errors++; $display("FAIL rst_async_toggle: got %b expected 0", bus.m_toggle); end
    checks++; if (bus.m_id !== 2'd0) begin errors++; $display("FAIL rst_async_m_id: got %0d expected 0", bus.m_id); end
    checks++; if (bus.m_data !== 8'h00) begin errors++; $display("FAIL rst_async_m_data: got %h expected 00", bus.m_data); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.s_ack !== 4'b0000 || bus.err !== 1'b0) begin errors++; $display("FAIL rst_async_ack_err: got %b/%b expected 0000/0", bus.s_ack, bus.err); end
    bus.s_req = 4'b1111;
    @(negedge clk);
    reset = 1'b0;
    model_last = N - 1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || int'(bus.m_id) != rr_model(4'b1111, model_last)) begin errors++; $display("FAIL rst_first_grant: got busy %b id %0d expected busy 1 id 0", bus.busy, bus.m_id); end
    bus.s_req = 4'b0000;
    repeat (20) @(negedge clk);
    $display("test_reset_mid_wait done");
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    model_last    = N - 1;
    reset         = 1'b1;
    loop_en       = 1'b1;
    bus.s_req     = '0;
    bus.s_data    = '0;
    bus.err_clear = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_random();
`ifdef JELLYVL_CDC_EVENT_ARBITER_TIMEOUT_EN
    test_timeout();
    test_err_clear_collision();
`else
    test_no_timeout();
`endif
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
